// File: rtl/cnn_pkg.sv
// Shared constants for the CNN layer blocks: sample and bus geometry,
// layer-1 map dimensions and the pooling receiver state encoding.
package cnn_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int KERNAL_NUM    = 6;
  localparam int ADDR_WIDTH    = 16;

  localparam int L1_IN_WIDTH   = 31;
  localparam int L1_IN_HEIGHT  = 31;
  localparam int L1_OUT_WIDTH  = L1_IN_WIDTH / 2;
  localparam int L1_OUT_HEIGHT = L1_IN_HEIGHT / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_e;

endpackage

// File: rtl/pool_max_vec.sv
// Per-lane signed maximum of two packed channel vectors (purely combinational).
// On a tie the common value is returned, so the choice of operand is irrelevant.
module pool_max_vec #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 6
) (
  input  logic [LANES*DATA_WIDTH-1:0] a_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  output logic [LANES*DATA_WIDTH-1:0] max_o
);

  // Lane-by-lane two's complement compare, no widening.
  always_comb begin
    max_o = '0;
    for (int j = 0; j < LANES; j++) begin
      if ($signed(a_i[j*DATA_WIDTH +: DATA_WIDTH]) >= $signed(b_i[j*DATA_WIDTH +: DATA_WIDTH]))
        max_o[j*DATA_WIDTH +: DATA_WIDTH] = a_i[j*DATA_WIDTH +: DATA_WIDTH];
      else
        max_o[j*DATA_WIDTH +: DATA_WIDTH] = b_i[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/pool2d_1.sv
// Layer-1 2x2/stride-2 max-pool receiver: consumes the 31x31 conv write
// stream, emits a 15x15 pooled map in raster order and pulses done at frame end.
// Optional build macro: POOL2D_1_ADDR_CHECK_EN adds a sticky check of the
// incoming beat address against the internal raster position.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for a frame, row/col counters at zero
// RUN     | receiving a frame
// DONE    | single cycle after the (last row, last col) beat
module pool2d_1 #(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int KERNAL_NUM = cnn_pkg::KERNAL_NUM,
  parameter int ADDR_WIDTH = cnn_pkg::ADDR_WIDTH,
  parameter int IN_WIDTH   = cnn_pkg::L1_IN_WIDTH,
  parameter int IN_HEIGHT  = cnn_pkg::L1_IN_HEIGHT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pool_1_in_wr_en,
  input  logic [ADDR_WIDTH-1:0]            pool_1_in_addr,
  input  logic [KERNAL_NUM*DATA_WIDTH-1:0] pool_1_in_bus,
  output logic                             pool_1_out_wr_en,
  output logic [ADDR_WIDTH-1:0]            pool_1_out_addr,
  output logic [KERNAL_NUM*DATA_WIDTH-1:0] pool_1_out_bus,
  output logic                             pool_1_done,
  output logic                             pool_1_addr_err
);
  import cnn_pkg::*;

  localparam int BUS_W      = KERNAL_NUM * DATA_WIDTH;
  localparam int OUT_WIDTH  = IN_WIDTH / 2;
  localparam int OUT_HEIGHT = IN_HEIGHT / 2;
  localparam int CW         = $clog2(IN_WIDTH);
  localparam int RW         = $clog2(IN_HEIGHT);
  localparam int LW         = $clog2(OUT_WIDTH);

  pool_state_e           state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [ADDR_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [BUS_W-1:0]      hold_q;
  logic [BUS_W-1:0]      linebuf_q [OUT_WIDTH];
  logic                  out_wr_en_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [BUS_W-1:0]      out_bus_q;

  logic             col_last, row_last, pair_col, pair_row;
  logic             hold_we, lb_we, emit;
  logic [LW-1:0]    lb_idx;
  logic [BUS_W-1:0] hmax, vmax;

  // Row/col are zero whenever the FSM is outside RUN (wrapped on the last
  // beat or cleared by reset), so the counters steer the datapath directly.
  assign col_last = (col_q == CW'(IN_WIDTH - 1));
  assign row_last = (row_q == RW'(IN_HEIGHT - 1));
  assign pair_col = col_q[0] && ((col_q >> 1) < CW'(OUT_WIDTH));
  assign pair_row = (row_q >> 1) < RW'(OUT_HEIGHT);
  assign lb_idx   = LW'(col_q >> 1);

  assign hold_we  = pool_1_in_wr_en && !col_q[0];
  assign lb_we    = pool_1_in_wr_en && pair_col && pair_row && !row_q[0];
  assign emit     = pool_1_in_wr_en && pair_col && pair_row &&  row_q[0];

  pool_max_vec #(.DATA_WIDTH(DATA_WIDTH), .LANES(KERNAL_NUM)) u_hmax (
    .a_i  (hold_q),
    .b_i  (pool_1_in_bus),
    .max_o(hmax)
  );

  pool_max_vec #(.DATA_WIDTH(DATA_WIDTH), .LANES(KERNAL_NUM)) u_vmax (
    .a_i  (linebuf_q[lb_idx]),
    .b_i  (hmax),
    .max_o(vmax)
  );

  // Next-state, raster counters and output index.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    out_cnt_d = out_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (pool_1_in_wr_en && col_last && row_last) state_d = ST_DONE;
      end
      default: begin
        state_d = pool_1_in_wr_en ? ST_RUN : ST_IDLE;
        if (pool_1_in_wr_en) out_cnt_d = '0;
      end
    endcase

    if (pool_1_in_wr_en) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // A frame-start beat is (0,0) and never emits, so this cannot race the clear.
    if (emit) out_cnt_d = out_cnt_q + 1'b1;
  end

  // State, counters, pairing storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_cnt_q   <= '0;
      hold_q      <= '0;
      out_wr_en_q <= 1'b0;
      out_addr_q  <= '0;
      out_bus_q   <= '0;
      for (int i = 0; i < OUT_WIDTH; i++) linebuf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_cnt_q   <= out_cnt_d;
      out_wr_en_q <= emit;
      if (hold_we) hold_q <= pool_1_in_bus;
      if (lb_we) linebuf_q[lb_idx] <= hmax;
      if (emit) begin
        out_addr_q <= out_cnt_q;
        out_bus_q  <= vmax;
      end
    end
  end

  assign pool_1_out_wr_en = out_wr_en_q;
  assign pool_1_out_addr  = out_addr_q;
  assign pool_1_out_bus   = out_bus_q;
  assign pool_1_done      = (state_q == ST_DONE);

`ifdef POOL2D_1_ADDR_CHECK_EN
  logic                  addr_err_q;
  logic [ADDR_WIDTH-1:0] exp_addr;

  assign exp_addr = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(IN_WIDTH) + ADDR_WIDTH'(col_q);

  // Sticky until reset; observation only, the datapath never sees it.
  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else if (pool_1_in_wr_en && (pool_1_in_addr != exp_addr)) addr_err_q <= 1'b1;
  end

  assign pool_1_addr_err = addr_err_q;
`else
  logic unused_addr;
  assign unused_addr     = ^pool_1_in_addr;
  assign pool_1_addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_pool2d_1.sv
// Scoreboard bench for pool2d_1: a frame-array reference model pushes the
// expected pooled beats and done pulses; a negedge monitor pops and compares.
module tb_pool2d_1;

  localparam int W  = 31;
  localparam int NB = 96;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_wr_en = 1'b0;
  logic [15:0]   in_addr = '0;
  logic [NB-1:0] in_bus = '0;
  logic          out_wr_en;
  logic [15:0]   out_addr;
  logic [NB-1:0] out_bus;
  logic          done;
  logic          addr_err;

  pool2d_1 dut (
    .clk             (clk),
    .rst             (rst),
    .pool_1_in_wr_en (in_wr_en),
    .pool_1_in_addr  (in_addr),
    .pool_1_in_bus   (in_bus),
    .pool_1_out_wr_en(out_wr_en),
    .pool_1_out_addr (out_addr),
    .pool_1_out_bus  (out_bus),
    .pool_1_done     (done),
    .pool_1_addr_err (addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            edge_n;
    int            addr;
    logic [NB-1:0] bus;
  } exp_t;

  exp_t          sbq[$];
  int            done_q[$];
  int            n_pass = 0;
  int            n_total = 0;
  int            strobe_cnt = 0;
  int            err_set_edge = -1;
  bit            capture_first = 0;
  logic [NB-1:0] first_bus = '0;

  // reference model state
  logic [NB-1:0] frame [W][W];
  int            m_r = 0, m_c = 0, m_k = 0;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [NB-1:0] max4(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                         input logic [NB-1:0] c, input logic [NB-1:0] d);
    logic [NB-1:0] res;
    logic signed [15:0] v [4];
    logic signed [15:0] m;
    res = '0;
    for (int j = 0; j < 6; j++) begin
      v[0] = a[16*j +: 16]; v[1] = b[16*j +: 16]; v[2] = c[16*j +: 16]; v[3] = d[16*j +: 16];
      m = v[0];
      for (int q = 1; q < 4; q++) if (v[q] > m) m = v[q];
      res[16*j +: 16] = m;
    end
    return res;
  endfunction

  // Frame-level model: store the beat at its raster position; every bottom-right
  // corner of a complete 2x2 window yields the max over that window.
  task automatic model_accept(input logic [NB-1:0] bus, input logic [15:0] addr, input int e);
    exp_t x;
`ifdef POOL2D_1_ADDR_CHECK_EN
    if (int'(addr) != m_r * W + m_c && err_set_edge < 0) err_set_edge = e;
`endif
    frame[m_r][m_c] = bus;
    if ((m_r % 2 == 1) && (m_c % 2 == 1) && m_r < W - 1 && m_c < W - 1) begin
      x.edge_n = e;
      x.addr   = m_k;
      x.bus    = max4(frame[m_r-1][m_c-1], frame[m_r-1][m_c], frame[m_r][m_c-1], bus);
      sbq.push_back(x);
      m_k++;
    end
    if (m_r == W - 1 && m_c == W - 1) begin
      done_q.push_back(e);
      m_r = 0; m_c = 0; m_k = 0;
    end else if (m_c == W - 1) begin
      m_c = 0; m_r++;
    end else begin
      m_c++;
    end
  endtask

  function automatic logic [NB-1:0] mk_bus(input int mode, input int i);
    logic [NB-1:0] b;
    for (int j = 0; j < 6; j++) begin
      case (mode)
        0:       b[16*j +: 16] = 16'(i + j);
        3:       b[16*j +: 16] = 16'($urandom_range(0, 8)) - 16'd4;
        default: b[16*j +: 16] = 16'($urandom);
      endcase
    end
    if (mode == 2) begin
      case (i)
        0:  begin b[15:0] = 16'hFFFB; b[95:80] = 16'h7FFF; end
        1:  begin b[15:0] = 16'hFFFD; b[95:80] = 16'h8000; end
        31: begin b[15:0] = 16'hFFF9; b[95:80] = 16'h0000; end
        32: begin b[15:0] = 16'hFFFC; b[95:80] = 16'h0001; end
        default: ;
      endcase
    end
    return b;
  endfunction

  task automatic drive_beat(input logic [NB-1:0] bus, input logic [15:0] addr);
    @(negedge clk);
    in_wr_en = 1'b1;
    in_bus   = bus;
    in_addr  = addr;
    model_accept(bus, addr, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_wr_en = 1'b0;
      in_bus   = {$urandom, $urandom, $urandom};
    end
  endtask

  // gap_mode: 0 back-to-back, 1 three idle cycles per beat, 2 random 0..2
  task automatic drive_frame(input int mode, input int gap_mode, input int last_idx, input int bad_idx);
    for (int i = 0; i <= last_idx; i++) begin
      drive_beat(mk_bus(mode, i), (i == bad_idx) ? 16'd7 : 16'(i));
      if (gap_mode == 1) idle(3);
      else if (gap_mode == 2) idle($urandom_range(0, 2));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_wr_en = 1'b0;
    @(negedge clk);
    chk("rst_out_wr_en", NB'(out_wr_en), '0);
    chk("rst_out_addr", NB'(out_addr), '0);
    chk("rst_out_bus", out_bus, '0);
    chk("rst_done", NB'(done), '0);
    chk("rst_addr_err", NB'(addr_err), '0);
    rst = 1'b0;
    m_r = 0; m_c = 0; m_k = 0;
    err_set_edge = -1;
    strobe_cnt   = 0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat or a done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_wr_en) begin
        strobe_cnt++;
        if (sbq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_strobe: got addr %0d expected no strobe (cycle %0d)", out_addr, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_addr", NB'(out_addr), NB'(e.addr));
          chk("out_bus", out_bus, e.bus);
          chk("out_latency", NB'(cyc), NB'(e.edge_n));
          chk("addr_err_flag", NB'(addr_err), NB'(err_set_edge >= 0 && cyc >= err_set_edge));
        end
        if (capture_first) begin
          first_bus     = out_bus;
          capture_first = 0;
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got pulse expected none (cycle %0d)", cyc);
        end else begin
          chk("done_cycle", NB'(cyc), NB'(done_q.pop_front()));
        end
        chk("strobes_per_frame", NB'(strobe_cnt), NB'(225));
        strobe_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out_wr_en", NB'(out_wr_en), '0);
    chk("reset_out_addr", NB'(out_addr), '0);
    chk("reset_out_bus", out_bus, '0);
    chk("reset_done", NB'(done), '0);
    chk("reset_addr_err", NB'(addr_err), '0);
    rst = 1'b0;
    idle(2);

    // ramp frame, back-to-back
    drive_frame(0, 0, 960, -1);
    idle(3);

    // signed max window planted in a random frame
    capture_first = 1;
    drive_frame(2, 0, 960, -1);
    idle(3);
    chk("signed_max_ch0", NB'(first_bus[15:0]), NB'(16'hFFFD));
    chk("signed_max_ch5", NB'(first_bus[95:80]), NB'(16'h7FFF));

    // gapped ramp
    drive_frame(0, 1, 960, -1);
    idle(3);

    // reset after beat 500, then a full ramp
    drive_frame(0, 0, 500, -1);
    do_reset();
    drive_frame(0, 0, 960, -1);
    idle(3);

    // back-to-back frames: second frame's first beat lands in DONE
    drive_frame(1, 0, 960, -1);
    drive_frame(3, 0, 960, -1);
    idle(3);

    // address check: beat 100 carries a wrong address
    drive_frame(0, 0, 960, 100);
    idle(3);
`ifdef POOL2D_1_ADDR_CHECK_EN
    chk("addr_err_sticky", NB'(addr_err), NB'(1));
`else
    chk("addr_err_tied_low", NB'(addr_err), NB'(0));
`endif
    do_reset();

    // random data with random gaps
    drive_frame(3, 2, 960, -1);
    idle(5);

    chk("scoreboard_drained", NB'(sbq.size()), '0);
    chk("done_queue_drained", NB'(done_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
